// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for alu_seq and alu_muldiv.
//   * 8-bit opcode encodings for the base and M-extension operations
//   * FSM state encoding used by the alu_seq controller
//   * opcode decode helpers (is_mop / is_signed / is_div / is_rem)
package alu_pkg;

    localparam logic [7:0] OP_ADD  = 8'h00;
    localparam logic [7:0] OP_SUB  = 8'h01;
    localparam logic [7:0] OP_AND  = 8'h02;
    localparam logic [7:0] OP_OR   = 8'h03;
    localparam logic [7:0] OP_XOR  = 8'h04;
    localparam logic [7:0] OP_INV  = 8'h05;
    localparam logic [7:0] OP_SLT  = 8'h06;
    localparam logic [7:0] OP_SLTU = 8'h07;
    localparam logic [7:0] OP_SLL  = 8'h08;
    localparam logic [7:0] OP_SRL  = 8'h09;
    localparam logic [7:0] OP_SRA  = 8'h0A;
    localparam logic [7:0] OP_MUL  = 8'h10;
    localparam logic [7:0] OP_MULH = 8'h11;
    localparam logic [7:0] OP_DIV  = 8'h12;
    localparam logic [7:0] OP_DIVU = 8'h13;
    localparam logic [7:0] OP_REM  = 8'h14;
    localparam logic [7:0] OP_REMU = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // M-extension opcode (multiply or divide family)
    function automatic logic is_mop(input logic [7:0] op);
        return (op >= OP_MUL) && (op <= OP_REMU);
    endfunction

    // Operands are interpreted as two's complement
    function automatic logic is_signed(input logic [7:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // Divide family (quotient or remainder)
    function automatic logic is_div(input logic [7:0] op);
        return (op >= OP_DIV) && (op <= OP_REMU);
    endfunction

    // Remainder result rather than quotient
    function automatic logic is_rem(input logic [7:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// alu_muldiv -- iterative WIDTH-step multiply / divide engine.
// Multiply is radix-2 shift-add, divide is restoring division; both work on
// operand magnitudes and the sign is applied to the final result.
// The first iteration is taken on the start edge itself, so o_done rises
// WIDTH-1 edges after start and the result is ready for capture on the next edge.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          load operands and begin (one-cycle pulse)
//   i_op             opcode (MUL/MULH/DIV/DIVU/REM/REMU)
//   i_a, i_b         operands
//   o_done           result valid on o_result (held until next edge)
//   o_result         sign-corrected result
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [7:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic [WIDTH-1:0] r_hi;       // product high half / partial remainder
    logic [WIDTH-1:0] r_lo;       // multiplier -> product low half / dividend -> quotient
    logic [WIDTH-1:0] r_m;        // multiplicand / divisor magnitude
    logic             r_div;
    logic             r_rem;
    logic             r_hiword;
    logic             r_neg_q;    // negate product or quotient
    logic             r_neg_r;    // negate remainder

    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic             w_is_div;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_div_cur;
    logic [WIDTH-1:0] w_hi_cur;
    logic [WIDTH-1:0] w_lo_cur;
    logic [WIDTH-1:0] w_m_cur;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_step;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0] w_quo;
    logic [WIDTH-1:0] w_remv;

    assign w_a_s    = i_a;
    assign w_b_s    = i_b;
    assign w_is_div = is_div(i_op);
    assign w_a_neg  = is_signed(i_op) && (w_a_s < 0);
    assign w_b_neg  = is_signed(i_op) && (w_b_s < 0);
    assign w_a_mag  = w_a_neg ? -i_a : i_a;
    assign w_b_mag  = w_b_neg ? -i_b : i_b;

    // On the start edge the step operates on freshly prepared operands
    assign w_div_cur = i_start ? w_is_div : r_div;
    assign w_hi_cur  = i_start ? '0 : r_hi;
    assign w_lo_cur  = i_start ? (w_is_div ? w_a_mag : w_b_mag) : r_lo;
    assign w_m_cur   = i_start ? (w_is_div ? w_b_mag : w_a_mag) : r_m;

    // Shift-add step: add multiplicand when multiplier LSB is set, shift right
    assign w_sum   = {1'b0, w_hi_cur} + (w_lo_cur[0] ? {1'b0, w_m_cur} : '0);
    // Restoring step: shift next dividend bit in, trial-subtract divisor
    assign w_shift = {w_hi_cur, w_lo_cur[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, w_m_cur};

    always_comb begin
        w_hi_nxt = w_hi_cur;
        w_lo_nxt = w_lo_cur;
        if (w_div_cur) begin
            if (!w_diff[WIDTH]) begin
                w_hi_nxt = w_diff[WIDTH-1:0];
                w_lo_nxt = {w_lo_cur[WIDTH-2:0], 1'b1};
            end else begin
                w_hi_nxt = w_shift[WIDTH-1:0];
                w_lo_nxt = {w_lo_cur[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_hi_nxt = w_sum[WIDTH:1];
            w_lo_nxt = {w_sum[0], w_lo_cur[WIDTH-1:1]};
        end
    end

    assign w_step = r_busy && (r_cnt != CNT_W'(WIDTH));
    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CNT_W'(1);
        end else if (o_done) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (w_step) begin
            r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_start) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
            r_m      <= w_m_cur;
            r_div    <= w_is_div;
            r_rem    <= is_rem(i_op);
            r_hiword <= (i_op == OP_MULH);
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
        end else if (w_step) begin
            r_hi     <= w_hi_nxt;
            r_lo     <= w_lo_nxt;
        end
    end

    // Sign fixup: product/quotient follow sign(A)^sign(B), remainder follows sign(A)
    assign w_prod  = r_neg_q ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_quo   = r_neg_q ? -r_lo : r_lo;
    assign w_remv  = r_neg_r ? -r_hi : r_hi;

    assign o_result = r_div    ? (r_rem ? w_remv : w_quo)
                    : r_hiword ? w_prod[2*WIDTH-1:WIDTH]
                    :            w_prod[WIDTH-1:0];

endmodule

// File: rtl/alu_seq.sv
// alu_seq -- multi-cycle RV32-style ALU with valid/ready handshakes.
// Base ops, illegal opcodes and divide early-outs complete in one registered
// cycle; MUL/MULH/DIV/DIVU/REM/REMU run on alu_muldiv for WIDTH cycles.
// Build option: define ALU_MULDIV_EN to compile in the M ops and alu_muldiv;
// without it opcodes 0x10-0x15 are reported as illegal.
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid / o_ready  request handshake (o_ready only in IDLE)
//   i_alu_op, i_a, i_b opcode and operands, captured on accept
//   o_valid / i_ready  result handshake
//   o_c, o_err         result and illegal-opcode flag, held while o_valid
module alu_seq
    import alu_pkg::*;
#(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [7:0]       i_alu_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_c,
    output logic             o_err
);

    state_t r_state;
    state_t w_state_nxt;
    logic [WIDTH-1:0] r_c;
    logic             r_err;

    logic                    w_accept;
    logic [SHW-1:0]          w_shamt;
    logic signed [WIDTH-1:0] w_a_s;
    logic signed [WIDTH-1:0] w_b_s;
    logic [WIDTH-1:0]        w_fast_c;
    logic                    w_fast_err;
    logic                    w_use_md;
    logic                    w_md_done;
    logic [WIDTH-1:0]        w_md_result;

    assign w_accept = i_valid && (r_state == ST_IDLE);
    assign w_shamt  = i_b[SHW-1:0];
    assign w_a_s    = i_a;
    assign w_b_s    = i_b;

`ifdef ALU_MULDIV_EN
    logic w_b_zero;
    logic w_ovf;

    assign w_b_zero = (i_b == '0);
    // most-negative / -1 overflows the quotient
    assign w_ovf    = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_start  (w_accept && w_use_md),
        .i_op     (i_alu_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_done   (w_md_done),
        .o_result (w_md_result)
    );
`else
    assign w_md_done   = 1'b0;
    assign w_md_result = '0;
`endif

    // Single-cycle result; w_use_md routes the op to the iterative engine instead
    always_comb begin
        w_fast_c   = '0;
        w_fast_err = 1'b0;
        w_use_md   = 1'b0;
        case (i_alu_op)
            OP_ADD:  w_fast_c = i_a + i_b;
            OP_SUB:  w_fast_c = i_a - i_b;
            OP_AND:  w_fast_c = i_a & i_b;
            OP_OR:   w_fast_c = i_a | i_b;
            OP_XOR:  w_fast_c = i_a ^ i_b;
            OP_INV:  w_fast_c = ~i_a;
            OP_SLT:  w_fast_c = {{(WIDTH-1){1'b0}}, (w_a_s < w_b_s)};
            OP_SLTU: w_fast_c = {{(WIDTH-1){1'b0}}, (i_a < i_b)};
            OP_SLL:  w_fast_c = i_a << w_shamt;
            OP_SRL:  w_fast_c = i_a >> w_shamt;
            OP_SRA:  w_fast_c = w_a_s >>> w_shamt;
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_MULH: w_use_md = 1'b1;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (w_b_zero) begin
                    w_fast_c = is_rem(i_alu_op) ? i_a : '1;
                end else if (is_signed(i_alu_op) && w_ovf) begin
                    w_fast_c = is_rem(i_alu_op) ? '0 : i_a;
                end else begin
                    w_use_md = 1'b1;
                end
            end
`endif
            default: w_fast_err = 1'b1;
        endcase
    end

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = w_use_md ? ST_BUSY : ST_DONE;
            ST_BUSY: if (w_md_done) w_state_nxt = ST_DONE;
            ST_DONE: if (i_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        o_ready = (r_state == ST_IDLE);
        o_valid = (r_state == ST_DONE);
        o_c     = r_c;
        o_err   = r_err;
    end

    // Result register, written only on the edge that enters DONE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_c   <= '0;
            r_err <= 1'b0;
        end else if (w_accept && !w_use_md) begin
            r_c   <= w_fast_c;
            r_err <= w_fast_err;
        end else if ((r_state == ST_BUSY) && w_md_done) begin
            r_c   <= w_md_result;
            r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int WIDTH = 32;
`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif
    localparam int MLAT = MD ? WIDTH + 1 : 1;

    typedef struct packed {
        logic [31:0] c;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [7:0]  i_alu_op;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_c;
    logic        o_err;

    exp_t sb[$];
    int   n_vec;
    int   n_err;

    alu_seq #(.WIDTH(WIDTH)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_alu_op (i_alu_op),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_c      (o_c),
        .o_err    (o_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compares every result handshake against the queue head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && o_valid && i_ready) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_result: got c=%h err=%b expected none", o_c, o_err);
                end else begin
                    e = sb.pop_front();
                    if (o_c !== e.c || o_err !== e.err) begin
                        n_err++;
                        $display("FAIL result: got c=%h err=%b expected c=%h err=%b",
                                 o_c, o_err, e.c, e.err);
                    end
                end
            end
        end
    end

    task automatic wait_valid(input string name, input int elat);
        int lat;
        lat = 1;
        while (!o_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_latency"}, lat, elat);
    endtask

    task automatic run(input string name, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ec, input logic ee,
                       input int elat, input int hold);
        logic [31:0] c0;
        logic        e0;
        @(posedge clk); #1;
        chk({name, "_ready"}, {31'd0, o_ready}, 32'd1);
        sb.push_back('{c: ec, err: ee});
        i_valid  = 1'b1;
        i_alu_op = op;
        i_a      = a;
        i_b      = b;
        @(posedge clk); #1;
        // scramble inputs after accept: the latched request must not see them
        i_valid  = 1'b0;
        i_alu_op = 8'h01;
        i_a      = ~a;
        i_b      = ~b;
        wait_valid(name, elat);
        c0 = o_c;
        e0 = o_err;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk({name, "_hold_c"}, o_c, c0);
            chk({name, "_hold_err_rdy_vld"}, {29'd0, o_err, o_ready, o_valid}, {29'd0, e0, 1'b0, 1'b1});
        end
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk({name, "_after_hs"}, {30'd0, o_ready, o_valid}, 32'd2);
    endtask

    task automatic run_m(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ec, input int hold);
        run(name, op, a, b, MD ? ec : 32'd0, !MD, MLAT, hold);
    endtask

    task automatic run_e(input string name, input logic [7:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] ec);
        run(name, op, a, b, MD ? ec : 32'd0, !MD, 1, 0);
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_alu_op = 8'h00;
        i_a      = '0;
        i_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {31'd0, o_ready}, 32'd1);
        chk("reset_valid", {31'd0, o_valid}, 32'd0);
        chk("reset_c", o_c, 32'd0);
        chk("reset_err", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // base ops
        run("add_wrap", 8'h00, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 5);
        run("sub",      8'h01, 32'h5,         32'h7,         32'hFFFF_FFFE, 1'b0, 1, 0);
        run("and",      8'h02, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1, 0);
        run("or",       8'h03, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1, 0);
        run("xor",      8'h04, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1, 0);
        run("inv",      8'h05, 32'h1234_5678, 32'h0,         32'hEDCB_A987, 1'b0, 1, 0);
        run("slt_neg",  8'h06, 32'hFFFF_FFFF, 32'h1,         32'h1,         1'b0, 1, 0);
        run("slt_pos",  8'h06, 32'h1,         32'hFFFF_FFFF, 32'h0,         1'b0, 1, 0);
        run("sltu_1",   8'h07, 32'h1,         32'hFFFF_FFFF, 32'h1,         1'b0, 1, 0);
        run("sltu_0",   8'h07, 32'hFFFF_FFFF, 32'h1,         32'h0,         1'b0, 1, 0);
        run("sll_mask", 8'h08, 32'h1,         32'h21,        32'h2,         1'b0, 1, 0);
        run("sll_31",   8'h08, 32'h1,         32'h1F,        32'h8000_0000, 1'b0, 1, 0);
        run("srl",      8'h09, 32'h8000_0000, 32'h1F,        32'h1,         1'b0, 1, 0);
        run("sra_neg",  8'h0A, 32'h8000_0000, 32'h1F,        32'hFFFF_FFFF, 1'b0, 1, 0);
        run("sra_pos",  8'h0A, 32'h4000_0000, 32'h1,         32'h2000_0000, 1'b0, 1, 0);
        run("ill_3f",   8'h3F, 32'h1234_5678, 32'h1,         32'h0,         1'b1, 1, 0);
        run("ill_0b",   8'h0B, 32'h5,         32'h5,         32'h0,         1'b1, 1, 0);

        // M ops (illegal when the multiply/divide unit is not built)
        run_m("mulh_neg", 8'h11, 32'h8000_0000, 32'h2,   32'hFFFF_FFFF, 5);
        run_m("mul",      8'h10, 32'h7,         32'h6,   32'h2A,        0);
        run_m("mul_neg",  8'h10, 32'hFFFF_FFFD, 32'h5,   32'hFFFF_FFF1, 0);
        run_m("mulh_n2",  8'h11, 32'hFFFF_FFFD, 32'h5,   32'hFFFF_FFFF, 0);
        run_m("mulh_pos", 8'h11, 32'h7,         32'h6,   32'h0,         0);
        run_m("div",      8'h12, 32'hFFFF_FFF9, 32'h2,   32'hFFFF_FFFD, 0);
        run_m("rem",      8'h14, 32'hFFFF_FFF9, 32'h2,   32'hFFFF_FFFF, 0);
        run_m("divu",     8'h13, 32'hFFFF_FFF9, 32'h2,   32'h7FFF_FFFC, 0);
        run_m("remu",     8'h15, 32'hFFFF_FFF9, 32'h2,   32'h1,         0);
        run_m("divu_m1",  8'h13, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,   0);
        run_e("div_zero",  8'h12, 32'h1234,      32'h0,         32'hFFFF_FFFF);
        run_e("rem_zero",  8'h14, 32'h1234,      32'h0,         32'h1234);
        run_e("divu_zero", 8'h13, 32'h55,        32'h0,         32'hFFFF_FFFF);
        run_e("remu_zero", 8'h15, 32'hFFFF_FF00, 32'h0,         32'hFFFF_FF00);
        run_e("div_ovf",   8'h12, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_e("rem_ovf",   8'h14, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // request presented in the same cycle as the result handshake
        @(posedge clk); #1;
        sb.push_back('{c: 32'd2, err: 1'b0});
        i_valid = 1'b1; i_alu_op = 8'h00; i_a = 32'd1; i_b = 32'd1;
        @(posedge clk); #1;
        i_valid = 1'b0;
        wait_valid("same_a", 1);
        sb.push_back('{c: 32'd10, err: 1'b0});
        i_valid = 1'b1; i_alu_op = 8'h00; i_a = 32'd3; i_b = 32'd7;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;
        chk("same_not_accepted", {30'd0, o_ready, o_valid}, 32'd2);
        @(posedge clk); #1;
        i_valid = 1'b0;
        chk("same_next_accept", {30'd0, o_ready, o_valid}, 32'd1);
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready = 1'b0;

        // asynchronous reset in the middle of a divide
        i_valid = 1'b1; i_alu_op = 8'h12; i_a = 32'd100; i_b = 32'd7;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ready_valid", {30'd0, o_ready, o_valid}, 32'd2);
        chk("arst_c", o_c, 32'd0);
        chk("arst_err", {31'd0, o_err}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run("add_after_rst", 8'h00, 32'd2, 32'd2, 32'd4, 1'b0, 1, 0);

        repeat (2) @(posedge clk);
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
